ep2_cmd_dispatch: RTL and testbench
===================================

Name: ep2_cmd_dispatch

Overview:
Host-to-device counterpart of the EP6 upstream combiner. It receives the 32-bit word stream unpacked from USB OUT endpoint EP2 and parses packet headers. Each packet's payload is routed to one of three downstream command channels. Malformed, unknown-channel and stalled packets are discarded, and every discard is counted. It sits between the EP2 read path and the per-channel command consumers, all in the clk_100 domain.

Parameters:
SYNC_WORD, 16'hA55A, required value of header bits [31:16]
TIMEOUT_CYC, 400, idle cycles allowed between payload words before a packet is aborted (legal range 2..65535)
CNT_W, 16, width of the error counters

Ports:
clk_100  input  1  system clock; all logic is rising-edge
rst_n  input  1  reset, synchronous, active-low
datain  input  32  EP2 word
datain_en  input  1  datain valid for one cycle; no backpressure, so a word is accepted whenever this is high
data1  output  32  channel 1 payload word
data1_en  output  1  data1 valid
data2  output  32  channel 2 payload word
data2_en  output  1  data2 valid
data3  output  32  channel 3 payload word
data3_en  output  1  data3 valid
pkt_done  output  1  one-cycle pulse when a packet completes successfully
pkt_chan  output  2  channel of the last completed packet; held until the next completion
sync_err_cnt  output  CNT_W  count of header words with a bad sync field; saturating
drop_cnt  output  CNT_W  count of dropped or aborted packets; saturating
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: when rst_n=0 at a clock edge, every output goes to 0 and the state goes to IDLE. A reset in the middle of a packet discards the rest of that packet, and the counters clear.
- Header format: [31:16] is the sync field, [15:8] is the channel id, [7:0] is the payload length LEN in words (0..255).
- State machine has three states: IDLE, PAYLOAD, DROP.
- IDLE, on datain_en:
  - Sync field != SYNC_WORD: discard the word, increment sync_err_cnt, stay in IDLE.
  - Channel id is 1..3 and LEN>0: latch channel and LEN into the remaining-words counter; go to PAYLOAD.
  - Channel id is 1..3 and LEN=0: pulse pkt_done, update pkt_chan, stay in IDLE.
  - Channel id is not 1..3 and LEN>0: go to DROP.
  - Channel id is not 1..3 and LEN=0: increment drop_cnt, stay in IDLE.
- PAYLOAD, on datain_en:
  - Copy the word to dataN and pulse dataN_en one cycle later (registered, latency 1). Only the latched channel's _en may be high.
  - Decrement the remaining counter.
  - On the last word, also pulse pkt_done in the same cycle as that word's dataN_en, and return to IDLE.
- DROP: consume LEN words with no output, then increment drop_cnt and return to IDLE.
- Timeout, in PAYLOAD or DROP:
  - An idle counter clears on every datain_en and increments otherwise.
  - When it reaches TIMEOUT_CYC: abort, increment drop_cnt, return to IDLE. Channel words already delivered are not retracted.
  - A datain_en in the same cycle the counter would reach TIMEOUT_CYC counts as arrival: the word is accepted and there is no abort.
  - The first word that arrives after an abort is parsed as a header.
- Sync values inside a payload are not inspected; payload words are opaque.
- Back-to-back packets: a header may arrive the cycle after the last payload word with no gap, so the block sustains full throughput.
- Counters saturate at all-ones and do not wrap.
- dataN holds its last value when dataN_en=0. Consumers must qualify with dataN_en.
- busy is combinational from the state register.

Test Plan:
- Reset, then header 32'hA55A_0203 followed by words 11,22,33 on consecutive cycles -> data2_en pulses 3 times with 11,22,33, each 1 cycle after input; pkt_done coincides with the 33 pulse; pkt_chan=2; data1_en and data3_en stay 0.
- Header 32'h1234_0101 -> sync_err_cnt=1, no output. Then a valid header 32'hA55A_0101 + word 7 -> data1=7 with data1_en=1.
- Header 32'hA55A_0902 + 2 words -> no dataN_en, drop_cnt=1. An immediately following 32'hA55A_0301 + word 5 -> data3=5.
- Header 32'hA55A_0104 + 2 words, then 400 idle cycles -> drop_cnt=1 and busy falls. The next word 32'hA55A_0100 gives a pkt_done pulse with pkt_chan=1.
- Header 32'hA55A_0105, word 1, then 399 idle cycles, then the remaining words -> no abort; all 5 words appear on data1.
- Assert rst_n=0 for 1 cycle mid-PAYLOAD -> outputs and counters 0; the next word is treated as a header. Also force 65536 bad headers -> sync_err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/ep2_cmd_dispatch.sv
// EP2 downstream command dispatcher: parses packet headers and routes
// payload words to one of three command channels.
module ep2_cmd_dispatch #(
  parameter logic [15:0] SYNC_WORD   = 16'hA55A,
  parameter int unsigned TIMEOUT_CYC = 400,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic [31:0]      datain,
  input  logic             datain_en,
  output logic [31:0]      data1,
  output logic             data1_en,
  output logic [31:0]      data2,
  output logic             data2_en,
  output logic [31:0]      data3,
  output logic             data3_en,
  output logic             pkt_done,
  output logic [1:0]       pkt_chan,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  chan_q, chan_d;
  logic [15:0] idle_q, idle_d;
  logic        deliver;
  logic        done;
  logic [1:0]  done_chan;
  logic        sync_inc;
  logic        drop_inc;

  logic        hdr_sync;
  logic [7:0]  hdr_id;
  logic [7:0]  hdr_len;
  logic        id_ok;

  assign hdr_sync = datain[31:16] == SYNC_WORD;
  assign hdr_id   = datain[15:8];
  assign hdr_len  = datain[7:0];
  assign id_ok    = hdr_id == 8'd1 || hdr_id == 8'd2 || hdr_id == 8'd3;
  assign busy     = state_q != S_IDLE;

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      chan_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      chan_q  <= chan_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    chan_d    = chan_q;
    idle_d    = idle_q;
    deliver   = 1'b0;
    done      = 1'b0;
    done_chan = chan_q;
    sync_inc  = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idle_d = '0;
        if (datain_en) begin
          if (!hdr_sync) begin
            sync_inc = 1'b1;
          end else if (id_ok) begin
            if (hdr_len != 8'd0) begin
              chan_d  = hdr_id[1:0];
              rem_d   = hdr_len;
              state_d = S_PAYLOAD;
            end else begin
              done      = 1'b1;
              done_chan = hdr_id[1:0];
            end
          end else if (hdr_len != 8'd0) begin
            rem_d   = hdr_len;
            state_d = S_DROP;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      S_PAYLOAD, S_DROP: begin
        if (datain_en) begin
          // arrival wins over a timeout landing on the same cycle
          idle_d  = '0;
          rem_d   = rem_q - 8'd1;
          deliver = state_q == S_PAYLOAD;
          if (rem_q == 8'd1) begin
            state_d  = S_IDLE;
            done     = state_q == S_PAYLOAD;
            drop_inc = state_q == S_DROP;
          end
        end else if (idle_q == IDLE_LAST) begin
          idle_d   = '0;
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      data1        <= '0;
      data2        <= '0;
      data3        <= '0;
      data1_en     <= 1'b0;
      data2_en     <= 1'b0;
      data3_en     <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_chan     <= '0;
      sync_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      data1_en <= deliver && chan_q == 2'd1;
      data2_en <= deliver && chan_q == 2'd2;
      data3_en <= deliver && chan_q == 2'd3;
      if (deliver && chan_q == 2'd1) data1 <= datain;
      if (deliver && chan_q == 2'd2) data2 <= datain;
      if (deliver && chan_q == 2'd3) data3 <= datain;
      pkt_done <= done;
      if (done) pkt_chan <= done_chan;
      if (sync_inc && sync_err_cnt != '1)
        sync_err_cnt <= sync_err_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ep2_cmd_dispatch.sv
// Bench for ep2_cmd_dispatch: packet-level reference model compared
// every cycle, plus literal spot checks from directed scenarios.
module tb_ep2_cmd_dispatch;

  localparam int TMO = 400;

  logic        clk_100 = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] datain = '0;
  logic        datain_en = 1'b0;
  logic [31:0] data1, data2, data3;
  logic        data1_en, data2_en, data3_en;
  logic        pkt_done;
  logic [1:0]  pkt_chan;
  logic [15:0] sync_err_cnt, drop_cnt;
  logic        busy;

  ep2_cmd_dispatch #(
    .SYNC_WORD(16'hA55A),
    .TIMEOUT_CYC(TMO),
    .CNT_W(16)
  ) dut (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .datain(datain),
    .datain_en(datain_en),
    .data1(data1),
    .data1_en(data1_en),
    .data2(data2),
    .data2_en(data2_en),
    .data3(data3),
    .data3_en(data3_en),
    .pkt_done(pkt_done),
    .pkt_chan(pkt_chan),
    .sync_err_cnt(sync_err_cnt),
    .drop_cnt(drop_cnt),
    .busy(busy)
  );

  always #5 clk_100 = ~clk_100;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: words_left counts payload still owed by the
  // current packet, target 0 means the packet is being discarded.
  int          words_left = 0;
  int          target = 0;
  int          silence = 0;
  logic [31:0] m_data [1:3];
  logic [3:1]  m_en = '0;
  logic        m_done = 1'b0;
  logic [1:0]  m_chan = '0;
  int          m_sync = 0;
  int          m_drop = 0;

  initial for (int k = 1; k <= 3; k++) m_data[k] = '0;

  always @(posedge clk_100) begin
    int id, len;
    m_en   = '0;
    m_done = 1'b0;
    if (!rst_n) begin
      words_left = 0;
      target = 0;
      silence = 0;
      for (int k = 1; k <= 3; k++) m_data[k] = '0;
      m_chan = '0;
      m_sync = 0;
      m_drop = 0;
    end else if (words_left == 0) begin
      if (datain_en) begin
        id  = int'(datain[15:8]);
        len = int'(datain[7:0]);
        if (datain[31:16] != 16'hA55A) begin
          if (m_sync < 65535) m_sync++;
        end else if (len == 0) begin
          if (id >= 1 && id <= 3) begin
            m_done = 1'b1;
            m_chan = 2'(id);
          end else if (m_drop < 65535) m_drop++;
        end else begin
          words_left = len;
          target = (id >= 1 && id <= 3) ? id : 0;
          silence = 0;
        end
      end
    end else if (datain_en) begin
      silence = 0;
      words_left--;
      if (target != 0) begin
        m_data[target] = datain;
        m_en[target] = 1'b1;
      end
      if (words_left == 0) begin
        if (target != 0) begin
          m_done = 1'b1;
          m_chan = 2'(target);
        end else if (m_drop < 65535) m_drop++;
      end
    end else begin
      silence++;
      if (silence == TMO) begin
        words_left = 0;
        if (m_drop < 65535) m_drop++;
      end
    end
  end

  always @(negedge clk_100) begin
    if (chk_on) begin
      chk("data1_en", 32'(data1_en), 32'(m_en[1]));
      chk("data2_en", 32'(data2_en), 32'(m_en[2]));
      chk("data3_en", 32'(data3_en), 32'(m_en[3]));
      chk("data1", data1, m_data[1]);
      chk("data2", data2, m_data[2]);
      chk("data3", data3, m_data[3]);
      chk("pkt_done", 32'(pkt_done), 32'(m_done));
      chk("pkt_chan", 32'(pkt_chan), 32'(m_chan));
      chk("sync_err_cnt", 32'(sync_err_cnt), 32'(m_sync));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("busy", 32'(busy), 32'(words_left != 0));
    end
  end

  task automatic send(input logic [31:0] w);
    datain = w;
    datain_en = 1'b1;
    @(posedge clk_100);
    #1;
    datain_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    datain_en = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_on = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_pkt_chan", 32'(pkt_chan), 32'd0);

    // normal three-word packet to channel 2
    send(32'hA55A_0203);
    send(32'd11);
    chk("t1_w1", data2, 32'd11);
    chk("t1_w1_en", 32'(data2_en), 32'd1);
    send(32'd22);
    chk("t1_w2", data2, 32'd22);
    chk("t1_w2_done", 32'(pkt_done), 32'd0);
    send(32'd33);
    chk("t1_w3", data2, 32'd33);
    chk("t1_done", 32'(pkt_done), 32'd1);
    chk("t1_chan", 32'(pkt_chan), 32'd2);
    chk("t1_d1_en", 32'(data1_en), 32'd0);
    idle(2);

    // bad sync, then valid channel-1 packet
    send(32'h1234_0101);
    chk("t2_sync", 32'(sync_err_cnt), 32'd1);
    send(32'hA55A_0101);
    send(32'd7);
    chk("t2_d1", data1, 32'd7);
    chk("t2_d1_en", 32'(data1_en), 32'd1);
    idle(2);

    // unknown channel dropped, then back-to-back channel-3 packet
    do_reset();
    send(32'hA55A_0902);
    send(32'hDEAD_0001);
    send(32'hBEEF_0002);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    send(32'hA55A_0301);
    send(32'd5);
    chk("t3_d3", data3, 32'd5);
    chk("t3_d3_en", 32'(data3_en), 32'd1);
    // unknown channel, zero length
    send(32'hA55A_0000);
    chk("t3_drop0", 32'(drop_cnt), 32'd2);
    idle(2);

    // timeout abort after exactly TMO idle cycles
    do_reset();
    send(32'hA55A_0104);
    send(32'd1);
    send(32'd2);
    idle(TMO - 1);
    chk("t4_busy_pre", 32'(busy), 32'd1);
    chk("t4_drop_pre", 32'(drop_cnt), 32'd0);
    idle(1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    send(32'hA55A_0100);
    chk("t4_done", 32'(pkt_done), 32'd1);
    chk("t4_chan", 32'(pkt_chan), 32'd1);
    idle(2);

    // word arriving on the last allowed cycle keeps the packet alive
    do_reset();
    send(32'hA55A_0105);
    send(32'd1);
    idle(TMO - 1);
    for (int i = 2; i <= 5; i++) send(32'(i));
    chk("t5_d1", data1, 32'd5);
    chk("t5_done", 32'(pkt_done), 32'd1);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    idle(2);

    // reset mid-payload
    send(32'hA55A_0104);
    send(32'd1);
    rst_n = 1'b0;
    @(posedge clk_100);
    #1;
    rst_n = 1'b1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_d1", data1, 32'd0);
    chk("t6_pkt_chan", 32'(pkt_chan), 32'd0);
    send(32'hA55A_0201);
    send(32'd9);
    chk("t6_d2", data2, 32'd9);

    // sync error counter saturation
    datain = 32'h0000_0000;
    datain_en = 1'b1;
    repeat (65535) @(posedge clk_100);
    #1;
    chk("t6_sat_edge", 32'(sync_err_cnt), 32'h0000_FFFF);
    repeat (1) @(posedge clk_100);
    #1;
    datain_en = 1'b0;
    chk("t6_sat_hold", 32'(sync_err_cnt), 32'h0000_FFFF);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
